// File: rtl/lb_print_sequencer_if.sv
// Print stream handshake toward the HPS print buffer.
// master drives data/valid/last, slave returns ready.
interface lb_print_sequencer_if #(
  parameter int DATA_W = 18
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              last;
  logic              ready;

  modport master (
    output data,
    output valid,
    output last,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  last,
    output ready
  );
endinterface

// File: rtl/lb_print_sequencer.sv
// Lattice node print sequencer: walks node memory into a credit FIFO stream.
// Optional trailing checksum word: define LB_PRINT_CHECKSUM_EN.
module lb_print_sequencer #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 18,
  parameter int NUM_NODES  = 1024,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        start_print,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_sel,
  input  logic [DATA_W-1:0] mem_rdata,
  lb_print_sequencer_if.master out,
  output logic              busy,
  output logic              done_print
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  logic [2:0]        state;
  logic              start_q;
  logic              start_edge;
  logic              abort;
  logic              go;
  logic              flush;
  logic [ADDR_W-1:0] addr;
  logic [RD_LAT-1:0] vld;
  logic [RD_LAT-1:0] lst;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     count;
  logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wp;
  logic [PW-1:0]     rp;
  logic [DATA_W:0]   wdata;
  logic [DATA_W:0]   head;
  logic              issue;
  logic              issue_last;
  logic              ret;
  logic              ret_last;
  logic              push_d;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              last_popped;
  logic              unused_ok;

  assign unused_ok  = ^start_print[7:4];
  assign start_edge = start_print[0] & ~start_q;
  assign abort      = start_print[1];
  assign go         = (state == S_IDLE) && start_edge && !abort;
  assign flush      = (state == S_FLUSH);

  // Credit rule: reads in flight plus stored words never exceed the FIFO.
  assign issue = (state == S_RUN) && !abort &&
                 (({1'b0, inflight} + {1'b0, count}) <
                  (CW + 1)'(FIFO_DEPTH));
  assign issue_last = issue && (addr == ADDR_W'(NUM_NODES - 1));

  assign ret      = vld[RD_LAT-1];
  assign ret_last = lst[RD_LAT-1];
  assign push_d   = ret && !flush;
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign head     = fifo_mem[rp];

  assign out.valid = !empty && !flush;
  assign out.data  = out.valid ? head[DATA_W-1:0] : '0;
  assign out.last  = out.valid & head[DATA_W];
  assign pop       = out.valid && out.ready;

  assign mem_rd   = issue;
  assign mem_addr = addr;
  assign busy     = (state == S_RUN) || (state == S_DRAIN) ||
                    (state == S_FLUSH);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++)
      inflight = inflight + CW'(vld[i]);
  end

`ifdef LB_PRINT_CHECKSUM_EN
  logic [DATA_W-1:0] acc;
  logic              csum_pend;
  logic              csum_push;

  assign csum_push = csum_pend && !flush && (!full || pop);
  assign push      = push_d || csum_push;
  assign wdata     = csum_push ? {1'b1, acc} : {1'b0, mem_rdata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      csum_pend <= 1'b0;
    end else if (go) begin
      acc       <= '0;
      csum_pend <= 1'b0;
    end else if (flush) begin
      csum_pend <= 1'b0;
    end else begin
      if (push_d)
        acc <= acc + mem_rdata;
      if (push_d && ret_last)
        csum_pend <= 1'b1;
      else if (csum_push)
        csum_pend <= 1'b0;
    end
  end
`else
  assign push  = push_d;
  assign wdata = {ret_last, mem_rdata};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
      lst <= '0;
    end else begin
      vld[0] <= issue;
      lst[0] <= issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        lst[i] <= lst[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wp] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always @(posedge clk) begin
    if (reset_n && !flush)
      assert (!(push && full && !pop));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      start_q     <= 1'b0;
      addr        <= '0;
      mem_sel     <= '0;
      done_print  <= 1'b0;
      last_popped <= 1'b0;
    end else begin
      start_q <= start_print[0];
      if (pop && out.last)
        last_popped <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (go) begin
            mem_sel     <= start_print[3:2];
            addr        <= '0;
            last_popped <= 1'b0;
            state       <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            state <= S_FLUSH;
          end else if (issue) begin
            addr <= addr + 1'b1;
            if (issue_last)
              state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (abort) begin
            state <= S_FLUSH;
          end else if (inflight == '0 && empty && last_popped) begin
            done_print <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (!start_print[0]) begin
            done_print <= 1'b0;
            state      <= S_IDLE;
          end
        end
        S_FLUSH: begin
          if (inflight == '0)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lb_print_sequencer.sv
// Directed bench for lb_print_sequencer (memory returns addr+BASE).
// With LB_PRINT_CHECKSUM_EN: 4 nodes, data 1..4, checksum word 10.
module tb_lb_print_sequencer;

`ifdef LB_PRINT_CHECKSUM_EN
  localparam int NN   = 4;
  localparam int BASE = 1;
  localparam int CS   = 1;
`else
  localparam int NN   = 8;
  localparam int BASE = 100;
  localparam int CS   = 0;
`endif
  localparam int AW = 10;
  localparam int DW = 18;
  localparam int RL = 2;
  localparam int FD = 4;
  localparam int NW = NN + CS;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [7:0]    start_print = 8'h00;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_sel;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          done_print;

  lb_print_sequencer_if #(.DATA_W(DW)) out_if ();

  lb_print_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_NODES(NN),
    .RD_LAT(RL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start_print(start_print),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_sel(mem_sel),
    .mem_rdata(mem_rdata),
    .out(out_if),
    .busy(busy),
    .done_print(done_print)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [RL-1:0] pv = '0;
  logic [AW-1:0] pa [RL];
  always @(posedge clk) begin
    pv    <= {pv[RL-2:0], mem_rd};
    pa[0] <= mem_addr;
    for (int i = 1; i < RL; i++) pa[i] <= pa[i-1];
  end
  assign mem_rdata = pv[RL-1] ? DW'(32'(pa[RL-1]) + BASE) : '0;

  logic [DW-1:0] got_d [$];
  logic          got_l [$];
  int            got_c [$];
  int            cyc = 0;
  int            rd_cnt = 0;
  int            stab_err = 0;
  logic          sv = 1'b0;
  logic          sr = 1'b0;
  logic [DW-1:0] sd = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd) rd_cnt <= rd_cnt + 1;
    if (out_if.valid && out_if.ready) begin
      got_d.push_back(out_if.data);
      got_l.push_back(out_if.last);
      got_c.push_back(cyc);
    end
    if (sv && !sr && (!out_if.valid || out_if.data != sd))
      stab_err <= stab_err + 1;
    sv <= out_if.valid;
    sr <= out_if.ready;
    sd <= out_if.data;
  end

  function automatic logic [DW-1:0] exp_word(int k);
    logic [DW-1:0] s;
    s = '0;
    if (k < NN) return DW'(BASE + k);
    for (int j = 0; j < NN; j++) s = s + DW'(BASE + j);
    return s;
  endfunction

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_print) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    out_if.ready = 1'b0;
    start_print  = 8'h00;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_rd, out_if.valid, out_if.last, busy, done_print} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 00000",
               {mem_rd, out_if.valid, out_if.last, busy, done_print});
    end
    checks++;
    if (mem_addr !== '0 || mem_sel !== '0) begin
      failures++;
      $display("FAIL reset_addr_sel: got addr=%0d sel=%0d required 0/0",
               mem_addr, mem_sel);
    end
    checks++;
    if (out_if.data !== '0) begin
      failures++;
      $display("FAIL reset_data: got %0d required 0", out_if.data);
    end
    reset_n = 1'b1;
    out_if.ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int b;
    int first;
    first = -1;
    b = got_d.size();
    start_print = 8'h01;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (out_if.valid && first < 0) first = i - 1;
      if (done_print) break;
    end
    checks++;
    if (first !== RL + 1) begin
      failures++;
      $display("FAIL basic_latency: got %0d cycles required %0d", first, RL + 1);
    end
    checks++;
    if (done_print !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_done: got done=%b busy=%b required 1/0",
               done_print, busy);
    end
    checks++;
    if (got_d.size() - b !== NW) begin
      failures++;
      $display("FAIL basic_count: got %0d words required %0d",
               got_d.size() - b, NW);
    end
    for (int k = 0; k < NW && b + k < got_d.size(); k++) begin
      checks++;
      if (got_d[b+k] !== exp_word(k) || got_l[b+k] !== (k == NW - 1) ||
          got_c[b+k] !== got_c[b] + k) begin
        failures++;
        $display("FAIL basic_word%0d: got d=%0d l=%b c=%0d required d=%0d l=%b c=%0d",
                 k, got_d[b+k], got_l[b+k], got_c[b+k] - got_c[b],
                 exp_word(k), (k == NW - 1), k);
      end
    end
    start_print = 8'h00;
    @(negedge clk);
    checks++;
    if (done_print !== 1'b0) begin
      failures++;
      $display("FAIL basic_clear: got done=%b required 0", done_print);
    end
  endtask

  task automatic test_stall();
    int b;
    int s0;
    b  = got_d.size();
    s0 = stab_err;
    start_print = 8'h01;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      out_if.ready = ~out_if.ready;
      if (done_print) break;
    end
    checks++;
    if (done_print !== 1'b1) begin
      failures++;
      $display("FAIL stall_done: got %b required 1", done_print);
    end
    checks++;
    if (got_d.size() - b !== NW) begin
      failures++;
      $display("FAIL stall_count: got %0d required %0d", got_d.size() - b, NW);
    end
    for (int k = 0; k < NW && b + k < got_d.size(); k++) begin
      checks++;
      if (got_d[b+k] !== exp_word(k) || got_l[b+k] !== (k == NW - 1)) begin
        failures++;
        $display("FAIL stall_word%0d: got d=%0d l=%b required d=%0d l=%b",
                 k, got_d[b+k], got_l[b+k], exp_word(k), (k == NW - 1));
      end
    end
    checks++;
    if (stab_err - s0 !== 0) begin
      failures++;
      $display("FAIL stall_stable: got %0d changes required 0", stab_err - s0);
    end
    out_if.ready = 1'b1;
    start_print = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hold_sel();
    int r0;
    bit ok;
    r0 = rd_cnt;
    start_print = 8'h0D;
    wait_done(100, ok);
    checks++;
    if (!ok || mem_sel !== 2'd3) begin
      failures++;
      $display("FAIL hold_first: got done=%b sel=%0d required 1/3", ok, mem_sel);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (done_print !== 1'b1 || rd_cnt - r0 !== NN) begin
      failures++;
      $display("FAIL hold_no_retrigger: got done=%b reads=%0d required 1/%0d",
               done_print, rd_cnt - r0, NN);
    end
    start_print = 8'h00;
    @(negedge clk);
    checks++;
    if (done_print !== 1'b0) begin
      failures++;
      $display("FAIL hold_clear: got %b required 0", done_print);
    end
    start_print = 8'h01;
    wait_done(100, ok);
    checks++;
    if (!ok || mem_sel !== 2'd0 || rd_cnt - r0 !== 2 * NN) begin
      failures++;
      $display("FAIL hold_second: got done=%b sel=%0d reads=%0d required 1/0/%0d",
               ok, mem_sel, rd_cnt - r0, 2 * NN);
    end
    start_print = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort();
    int r0;
    bit seen_done;
    seen_done = 1'b0;
    r0 = rd_cnt;
    start_print = 8'h01;
    for (int i = 0; i < 20 && rd_cnt - r0 < 3; i++) @(negedge clk);
    start_print = 8'h03;
    #1;
    checks++;
    if (mem_rd !== 1'b0 || rd_cnt - r0 !== 3) begin
      failures++;
      $display("FAIL abort_rd_stop: got rd=%b reads=%0d required 0/3",
               mem_rd, rd_cnt - r0);
    end
    @(negedge clk);
    checks++;
    if (out_if.valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_flush: got valid=%b busy=%b required 0/1",
               out_if.valid, busy);
    end
    for (int i = 0; i < 20 && busy; i++) begin
      @(negedge clk);
      if (done_print) seen_done = 1'b1;
    end
    checks++;
    if (busy !== 1'b0 || seen_done !== 1'b0 || rd_cnt - r0 !== 3) begin
      failures++;
      $display("FAIL abort_idle: got busy=%b done=%b reads=%0d required 0/0/3",
               busy, seen_done, rd_cnt - r0);
    end
    start_print = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int b;
    bit ok;
    start_print = 8'h01;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy && mem_addr == AW'(NN / 2 + 1)) break;
    end
    checks++;
    if (mem_addr !== AW'(NN / 2 + 1)) begin
      failures++;
      $display("FAIL midreset_reach: got addr=%0d required %0d",
               mem_addr, NN / 2 + 1);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_rd, mem_addr, mem_sel, out_if.valid, out_if.last,
         out_if.data, busy, done_print} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: got rd=%b addr=%0d valid=%b busy=%b required all 0",
               mem_rd, mem_addr, out_if.valid, busy);
    end
    @(negedge clk);
    start_print = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    b = got_d.size();
    start_print = 8'h01;
    @(negedge clk);
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== '0) begin
      failures++;
      $display("FAIL midreset_restart: got rd=%b addr=%0d required 1/0",
               mem_rd, mem_addr);
    end
    wait_done(100, ok);
    checks++;
    if (!ok || got_d.size() - b !== NW) begin
      failures++;
      $display("FAIL midreset_print: got done=%b words=%0d required 1/%0d",
               ok, got_d.size() - b, NW);
    end
    start_print = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    out_if.ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_hold_sel();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lb_print_sequencer.md
Name: lb_print_sequencer

Overview:
- Downstream consumer of the 8-bit start_print PIO byte written by the HPS.
- On a start request, walks every lattice node in the node memory and issues reads with a fixed read latency.
- Streams the returned words through a credit-controlled FIFO onto a valid/ready output toward the HPS print buffer.
- Reports busy and done so the HPS can complete a write-1 / wait-done / write-0 handshake.

Parameters:
- ADDR_W, 10, node memory address width.
- DATA_W, 18, node data word width.
- NUM_NODES, 1024, number of nodes walked per print (1..2^ADDR_W).
- RD_LAT, 2, fixed node memory read latency in cycles (>=1).
- FIFO_DEPTH, 4, output FIFO entries (power of two, >= RD_LAT+1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- start_print  in  8  PIO byte:
  - bit0 = start request.
  - bit1 = abort.
  - bits[3:2] = field select.
  - bits[7:4] = ignored.
- mem_rd  out  1  node memory read strobe.
- mem_addr  out  ADDR_W  node memory read address.
- mem_sel  out  2  latched field select.
- mem_rdata  in  DATA_W  read data, valid RD_LAT cycles after mem_rd.
- out_data  out  DATA_W  stream data.
- out_valid  out  1  stream valid.
- out_last  out  1  marks final word of a print.
- out_ready  in  1  stream ready from sink.
- busy  out  1  high in RUN, DRAIN and FLUSH.
- done_print  out  1  print complete flag.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All outputs 0; mem_addr = 0; mem_sel = 0.
  - FIFO empty; in-flight pipeline cleared; start edge register = 0.
- Start detection: registered copy of bit0. A print starts on a 0->1 edge only; a held 1 never retriggers.
- IDLE:
  - On a start edge with bit1 = 0: latch bits[3:2] into mem_sel, set addr = 0, go to RUN.
  - A start edge with bit1 = 1 is ignored.
- RUN:
  - Issue mem_rd with mem_addr = addr when inflight + fifo_count < FIFO_DEPTH.
  - Each issue increments addr.
  - When the issued address is NUM_NODES-1, go to DRAIN. No more reads are issued.
- Read return:
  - RD_LAT-stage valid shift register tags returning words.
  - A tagged word is pushed into the FIFO at cycle issue+RD_LAT.
  - The credit rule guarantees the FIFO never overflows; assert this in simulation.
- Output stream:
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - Pop when out_valid && out_ready.
  - out_data and out_valid hold stable while out_valid && !out_ready.
- out_last: high exactly with the NUM_NODES-th word, or the checksum word when that feature is compiled in.
- DRAIN: when inflight = 0, the FIFO is empty and the last pop has occurred, set done_print = 1 and go to DONE.
- DONE:
  - done_print stays 1 while bit0 = 1.
  - When bit0 = 0, clear done_print and go to IDLE.
- Abort: bit1 = 1 in RUN or DRAIN:
  - Stop issuing reads immediately and go to FLUSH.
  - FLUSH discards in-flight returns, clears the FIFO and forces out_valid = 0.
  - Go to IDLE once inflight = 0. done_print is never set.
- Simultaneous events in the same cycle:
  - Abort has priority over the last issue.
  - A FIFO push and pop together leave the count unchanged.
- Throughput: one word per cycle when out_ready is held high. First out_valid appears RD_LAT+1 cycles after the start edge.
- NUM_NODES = 1: RUN issues one read then goes to DRAIN; out_last is set on that word.

Optional Feature:
- Macro: LB_PRINT_CHECKSUM_EN.
- Defined:
  - A DATA_W accumulator sums every pushed word, modulo 2^DATA_W. It is cleared when a print starts.
  - After the NUM_NODES-th word is pushed, one extra checksum word is pushed; it consumes one FIFO credit.
  - out_last moves to the checksum word.
  - DRAIN waits for the checksum word to be popped.
- Undefined: no accumulator and no extra word; out_last is on node NUM_NODES-1.

Test Plan:
- NUM_NODES=8, memory returns addr+100, out_ready=1, start 0x01 -> 8 words 100..107 on consecutive cycles, out_last on 107, done_print=1, busy=0. Then write 0x00 -> done_print=0 next cycle.
- Same setup, out_ready toggles 1/0 each cycle -> no word lost or duplicated, FIFO count never exceeds 4, out_data stable while stalled.
- start_print 0x0D, then held at 0x0D after done -> mem_sel=3, exactly one print. Write 0x00 then 0x01 -> a second print runs.
- Abort: 0x03 written after 3 reads issued -> mem_rd stops the same cycle, out_valid=0 within 1 cycle, state returns to IDLE, done_print stays 0.
- reset_n pulsed low mid-RUN with addr=5 -> all outputs 0 immediately. After release a new start edge restarts from addr 0.
- With LB_PRINT_CHECKSUM_EN, NUM_NODES=4, data 1,2,3,4 -> 5th word = 10 with out_last; words 1..4 have out_last=0.
